temp_to_dig_avg: RTL and testbench

Parametrised successor of the single-shot temperature-to-digital counter. It drives the relaxation oscillator's discharge pulse (RESET) and times each charge phase until the comparator output `analog_out` rises. It averages 2^AVG_LOG2 charge times into one result and flags saturation. It sits between the analog temperature sensor front end and the digital readout, and publishes one averaged code per conversion with a valid strobe.

---
 rtl/temp_to_dig_avg.sv | 148 ++++++++++++++
 tb/tb_temp_to_dig_avg.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/temp_to_dig_avg.sv
// Temperature-to-digital converter with sample averaging.
// Drives the relaxation-oscillator discharge pulse, times each charge phase
// until the comparator rises (or the counter saturates), and publishes the
// truncated mean of 2^AVG_LOG2 charge times with a one-cycle valid strobe.
module temp_to_dig_avg #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned AVG_LOG2    = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RST_CYCLES  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             analog_out,
    input  logic             enable,
    output logic [CNT_W-1:0] b,
    output logic             valid,
    output logic             ovf,
    output logic             RESET,
    output logic             busy
);

    localparam int unsigned ACC_W       = CNT_W + AVG_LOG2;
    localparam int unsigned IDX_W       = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned RC_W        = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int unsigned NUM_SAMPLES = 1 << AVG_LOG2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DISCHARGE = 2'd1,
        CHARGE    = 2'd2
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev;
    logic [CNT_W-1:0]       counter;
    logic [RC_W-1:0]        rst_cnt;
    logic [ACC_W-1:0]       acc;
    logic [IDX_W-1:0]       idx;
    logic                   sat_any;

    logic                   rise_c;
    logic                   timeout_c;
    logic                   done_c;
    logic                   sat_flag_c;
    logic                   last_c;
    logic [CNT_W-1:0]       sample_c;
    logic [ACC_W-1:0]       sum_c;

    // Bring the comparator into the clock domain and keep its delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], analog_out};
            prev   <= sync_q[SYNC_STAGES-1];
        end
    end

    // Sample completion: a rising edge wins over the saturation timeout
    always_comb begin
        rise_c     = sync_q[SYNC_STAGES-1] & ~prev;
        timeout_c  = (counter == {CNT_W{1'b1}});
        done_c     = (state == CHARGE) && (rise_c || timeout_c);
        sat_flag_c = !rise_c && timeout_c;
        sample_c   = rise_c ? counter : {CNT_W{1'b1}};
        sum_c      = acc + ACC_W'(sample_c);
        last_c     = (idx == IDX_W'(NUM_SAMPLES - 1));
    end

    // Conversion sequencer with registered discharge pulse, busy and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            counter <= '0;
            rst_cnt <= '0;
            acc     <= '0;
            idx     <= '0;
            sat_any <= 1'b0;
            b       <= '0;
            valid   <= 1'b0;
            ovf     <= 1'b0;
            RESET   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (!enable) begin
                // Abort: drop the partial average, keep the last published result
                state   <= IDLE;
                counter <= '0;
                rst_cnt <= '0;
                acc     <= '0;
                idx     <= '0;
                sat_any <= 1'b0;
                RESET   <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state   <= DISCHARGE;
                        counter <= '0;
                        rst_cnt <= '0;
                        RESET   <= 1'b1;
                        busy    <= 1'b1;
                    end
                    DISCHARGE: begin
                        counter <= '0;
                        if (rst_cnt == RC_W'(RST_CYCLES - 1)) begin
                            state <= CHARGE;
                            RESET <= 1'b0;
                        end else begin
                            rst_cnt <= rst_cnt + 1'b1;
                        end
                    end
                    CHARGE: begin
                        if (done_c) begin
                            state   <= DISCHARGE;
                            counter <= '0;
                            rst_cnt <= '0;
                            RESET   <= 1'b1;
                            if (last_c) begin
                                b       <= CNT_W'(sum_c >> AVG_LOG2);
                                ovf     <= sat_any | sat_flag_c;
                                valid   <= 1'b1;
                                acc     <= '0;
                                idx     <= '0;
                                sat_any <= 1'b0;
                            end else begin
                                acc     <= sum_c;
                                idx     <= idx + 1'b1;
                                sat_any <= sat_any | sat_flag_c;
                            end
                        end else begin
                            counter <= counter + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        RESET <= 1'b0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_temp_to_dig_avg.sv
// Self-checking bench for temp_to_dig_avg: directed table, abort/reset
// sequences, and randomized sets checked against an arithmetic model.
module tb_temp_to_dig_avg;

    localparam int unsigned CNT_W       = 8;
    localparam int unsigned AVG_LOG2    = 2;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned RST_CYCLES  = 4;
    localparam int          MAXC        = (1 << CNT_W) - 1;
    localparam int          NSAMP       = 1 << AVG_LOG2;

    logic             clk;
    logic             rst_n;
    logic             analog_out;
    logic             enable;
    logic [CNT_W-1:0] b;
    logic             valid;
    logic             ovf;
    logic             RESET;
    logic             busy;

    temp_to_dig_avg #(
        .CNT_W      (CNT_W),
        .AVG_LOG2   (AVG_LOG2),
        .SYNC_STAGES(SYNC_STAGES),
        .RST_CYCLES (RST_CYCLES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .analog_out(analog_out),
        .enable    (enable),
        .b         (b),
        .valid     (valid),
        .ovf       (ovf),
        .RESET     (RESET),
        .busy      (busy)
    );

    typedef struct {
        string tag;
        int    n0, n1, n2, n3;
        bit    hold;
        int    eb;
        int    eo;
        int    elat;
    } vec_t;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   vcount = 0;
    int   exv    = 0;
    int   dis_cyc, valid_cyc, set_start;
    int   last_b, last_ovf;
    int   cur_n [NSAMP];
    vec_t tbl [6];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;
    always @(negedge clk) if (valid) vcount++;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // Spec rules: rise at CHARGE edge N captures N+SYNC_STAGES unless that
    // exceeds the counter range, in which case the sample saturates.
    function automatic int m_sample(input int n);
        return (n >= 0 && n + SYNC_STAGES <= MAXC) ? n + SYNC_STAGES : MAXC;
    endfunction

    function automatic int m_sat(input int n);
        return (n >= 0 && n + SYNC_STAGES <= MAXC) ? 0 : 1;
    endfunction

    // One sample: wait for discharge, check its width, then raise the comparator at CHARGE edge n
    task automatic run_sample(input int n, input bit hold);
        int i;
        int cnt;
        i = 0;
        while (!RESET && i < 2000) begin
            @(posedge clk); #1;
            i++;
        end
        if (!RESET) begin
            timeout_fail("discharge wait");
            return;
        end
        dis_cyc    = cyc;
        analog_out = hold;
        cnt = 0;
        while (RESET && cnt < 100) begin
            cnt++;
            @(posedge clk); #1;
        end
        check("RESET width", cnt, RST_CYCLES);
        if (n >= 0 && n + SYNC_STAGES <= MAXC) begin
            repeat (n) @(posedge clk);
            #1;
            analog_out = 1'b1;
        end
    endtask

    task automatic wait_valid();
        int i;
        i = 0;
        while (!valid && i < 600) begin
            @(posedge clk); #1;
            i++;
        end
        if (!valid) timeout_fail("valid wait");
        valid_cyc = cyc;
    endtask

    task automatic run_set(input string tag, input bit hold, input int eb, input int eo, input int elat);
        for (int k = 0; k < NSAMP; k++) begin
            run_sample(cur_n[k], hold);
            if (k == 0) set_start = dis_cyc;
        end
        wait_valid();
        check({tag, " b"}, int'(b), eb);
        check({tag, " ovf"}, int'(ovf), eo);
        check({tag, " latency"}, valid_cyc - set_start, elat);
        exv++;
        last_b   = eb;
        last_ovf = eo;
    endtask

    initial begin
        tbl[0] = '{"nominal",   8,  10,  12,  14, 1'b0,  13, 0,   72};
        tbl[1] = '{"trunc",     8,   8,   8,   9, 1'b0,  10, 0,   61};
        tbl[2] = '{"stuck_low", -1, -1,  -1,  -1, 1'b0, 255, 1, 1040};
        tbl[3] = '{"stuck_hi",  -1, -1,  -1,  -1, 1'b1, 255, 1, 1040};
        tbl[4] = '{"recover",   8,   8,   8,   8, 1'b0,  10, 0,   60};
        tbl[5] = '{"mixed",     0, 253, 254, 100, 1'b0, 153, 1,  634};

        rst_n      = 1'b1;
        enable     = 1'b0;
        analog_out = 1'b0;
        last_b     = 0;
        last_ovf   = 0;
        #2 rst_n = 1'b0;
        #1;
        check("rst b", int'(b), 0);
        check("rst valid", int'(valid), 0);
        check("rst ovf", int'(ovf), 0);
        check("rst RESET", int'(RESET), 0);
        check("rst busy", int'(busy), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle busy", int'(busy), 0);
        check("idle RESET", int'(RESET), 0);

        // Directed table, back-to-back conversions
        enable = 1'b1;
        for (int t = 0; t < 6; t++) begin
            cur_n[0] = tbl[t].n0;
            cur_n[1] = tbl[t].n1;
            cur_n[2] = tbl[t].n2;
            cur_n[3] = tbl[t].n3;
            run_set(tbl[t].tag, tbl[t].hold, tbl[t].eb, tbl[t].eo, tbl[t].elat);
        end

        // Abort in CHARGE of sample 2, partial sum must be discarded
        run_sample(20, 1'b0);
        run_sample(20, 1'b0);
        run_sample(-1, 1'b0);
        repeat (5) @(posedge clk);
        #1 enable = 1'b0;
        @(posedge clk); #1;
        check("abort busy", int'(busy), 0);
        check("abort RESET", int'(RESET), 0);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("abort b held", int'(b), last_b);
        check("abort ovf held", int'(ovf), last_ovf);
        check("abort no valid", vcount, exv);
        check("abort stays idle", int'(busy), 0);
        @(posedge clk); #1;
        enable = 1'b1;
        for (int k = 0; k < NSAMP; k++) cur_n[k] = 8;
        run_set("reenable", 1'b0, 10, 0, 60);

        // Asynchronous reset in the middle of a discharge
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async b", int'(b), 0);
        check("async valid", int'(valid), 0);
        check("async ovf", int'(ovf), 0);
        check("async RESET", int'(RESET), 0);
        check("async busy", int'(busy), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        last_b   = 0;
        last_ovf = 0;

        // Randomized sets against the arithmetic model
        for (int s = 0; s < 8; s++) begin
            int sum;
            int anysat;
            int lat;
            sum    = 0;
            anysat = 0;
            lat    = 0;
            for (int k = 0; k < NSAMP; k++) begin
                if ($urandom_range(0, 15) == 0) cur_n[k] = -1;
                else cur_n[k] = int'($urandom_range(0, 259));
                sum    += m_sample(cur_n[k]);
                anysat |= m_sat(cur_n[k]);
                lat    += RST_CYCLES + m_sample(cur_n[k]) + 1;
            end
            run_set($sformatf("rand%0d", s), 1'b0, sum / NSAMP, anysat, lat);
        end

        @(negedge clk); #1;
        check("valid pulse count", vcount, exv);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
